// File: rtl/lif_neuron_array.sv
// Multi-channel leaky integrate-and-fire neuron core with shared configuration,
// membrane-potential monitor and a saturating output spike counter.
module lif_neuron_array #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned W           = 8,
  parameter int unsigned THRESH_INIT = 100,
  parameter int unsigned WEIGHT_INIT = 30,
  parameter int unsigned LEAK_INIT   = 0,
  parameter int unsigned REFRAC_INIT = 0,
  localparam int unsigned SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [N_CH-1:0]  spike_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [W-1:0]     cfg_data,
  input  logic [SEL_W-1:0] v_sel,
  output logic [N_CH-1:0]  spike_out,
  output logic [W-1:0]     v_mon,
  output logic [15:0]      spike_count
);

  logic [W-1:0]    thr_q, wgt_q;
  logic [3:0]      lk_q;
  logic [7:0]      rf_q;

  logic [W-1:0]    v_q [N_CH];
  logic [W-1:0]    v_d [N_CH];
  logic [7:0]      r_q [N_CH];
  logic [7:0]      r_d [N_CH];
  logic [N_CH-1:0] fire_d, spike_q;
  logic [W-1:0]    v_mon_d, v_mon_q;
  logic [15:0]     count_d, count_q;
  logic [16:0]     count_sum;

  // Shared configuration; a write never affects the step sampled in the same cycle
  // because the datapath only ever reads the registered values.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q <= W'(THRESH_INIT);
      wgt_q <= W'(WEIGHT_INIT);
      lk_q  <= 4'(LEAK_INIT);
      rf_q  <= 8'(REFRAC_INIT);
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd0:    thr_q <= cfg_data;
        2'd1:    wgt_q <= cfg_data;
        2'd2:    lk_q  <= cfg_data[3:0];
        default: rf_q  <= 8'(cfg_data);
      endcase
    end
  end

  always_comb begin
    fire_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      logic [W-1:0] leak;
      logic [W:0]   sum;
      logic [W-1:0] sat;
      leak = (lk_q == 4'd0) ? '0 : (v_q[i] >> lk_q);
      // W+1 bits: V-L is non-negative, adding the weight may carry into bit W.
      sum  = {1'b0, v_q[i]} - {1'b0, leak} + (spike_in[i] ? {1'b0, wgt_q} : '0);
      sat  = sum[W] ? '1 : sum[W-1:0];
      v_d[i] = v_q[i];
      r_d[i] = r_q[i];
      if (step) begin
        if (r_q[i] != 8'd0) begin
          r_d[i] = r_q[i] - 8'd1;
          v_d[i] = '0;
        end else if (sat >= thr_q) begin
          fire_d[i] = 1'b1;
          v_d[i]    = '0;
          r_d[i]    = rf_q;
        end else begin
          v_d[i] = sat;
        end
      end
    end
  end

  always_comb begin
    count_sum = {1'b0, count_q};
    for (int i = 0; i < N_CH; i++) begin
      count_sum = count_sum + 17'(fire_d[i]);
    end
    count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  always_comb begin
    v_mon_d = '0;
    if (32'(v_sel) < N_CH) begin
      v_mon_d = v_q[v_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
      spike_q <= '0;
      v_mon_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        v_q[i] <= v_d[i];
        r_q[i] <= r_d[i];
      end
      spike_q <= fire_d;
      v_mon_q <= v_mon_d;
      count_q <= count_d;
    end
  end

  assign spike_out   = spike_q;
  assign v_mon       = v_mon_q;
  assign spike_count = count_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: a behavioural model pushes expected outputs
// per clock into a scoreboard queue, popped and compared on the following falling edge.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic [3:0]  spike_in = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [7:0]  cfg_data = '0;
  logic [1:0]  v_sel = '0;
  logic [3:0]  spike_out;
  logic [7:0]  v_mon;
  logic [15:0] spike_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  spk;
    logic [7:0]  vm;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  int mv[4];
  int mr[4];
  int mthr, mwgt, mlk, mrf, mcnt;

  always #5 clk = ~clk;

  lif_neuron_array #(
    .N_CH(4), .W(8), .THRESH_INIT(100), .WEIGHT_INIT(30), .LEAK_INIT(0), .REFRAC_INIT(0)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .spike_in(spike_in), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .v_sel(v_sel), .spike_out(spike_out),
    .v_mon(v_mon), .spike_count(spike_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: model the edge, push expectation, clock, pop and compare.
  task automatic tick(input string tag);
    exp_t e;
    int s, l, pop;
    e.spk = '0;
    if (rst) begin
      foreach (mv[i]) begin mv[i] = 0; mr[i] = 0; end
      mthr = 100; mwgt = 30; mlk = 0; mrf = 0; mcnt = 0;
      e.vm = 0;
    end else begin
      e.vm = 8'(mv[v_sel]);
      pop = 0;
      if (step) begin
        for (int i = 0; i < 4; i++) begin
          if (mr[i] > 0) begin
            mr[i]--;
            mv[i] = 0;
          end else begin
            l = (mlk == 0) ? 0 : (mv[i] >> mlk);
            s = mv[i] - l + (spike_in[i] ? mwgt : 0);
            if (s > 255) s = 255;
            if (s >= mthr) begin
              e.spk[i] = 1'b1; pop++; mv[i] = 0; mr[i] = mrf;
            end else begin
              mv[i] = s;
            end
          end
        end
      end
      mcnt = (mcnt + pop > 65535) ? 65535 : mcnt + pop;
      if (cfg_we) begin
        case (cfg_sel)
          2'd0: mthr = cfg_data;
          2'd1: mwgt = cfg_data;
          2'd2: mlk  = cfg_data & 15;
          default: mrf = cfg_data;
        endcase
      end
    end
    e.cnt = 16'(mcnt);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_spike"}, spike_out, e.spk);
    chk({tag, "_vmon"}, v_mon, e.vm);
    chk({tag, "_count"}, spike_count, e.cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick("reset");
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    tick("cfg");
    cfg_we = 1'b0;
  endtask

  task automatic stp(input string tag, input logic [3:0] vec, input int n);
    step = 1'b1; spike_in = vec;
    repeat (n) tick(tag);
    step = 1'b0; spike_in = '0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_count", spike_count, 0);

    // Linear integration: 30, 60, 90, fire on 4th step.
    v_sel = 2'd0;
    stp("linear", 4'b0001, 4);
    chk("linear_fire", spike_out, 4'b0001);
    chk("linear_vmon_90", v_mon, 90);
    tick("linear_idle");
    chk("linear_count", spike_count, 1);
    chk("linear_v0", v_mon, 0);

    // Leak shift 2: 30, 53, 70, 83, 93, fire on 6th step.
    do_reset();
    cfg(2'd2, 8'd2);
    stp("leak", 4'b0001, 5);
    chk("leak_no_spike", spike_count, 0);
    stp("leak6", 4'b0001, 1);
    chk("leak_fire", spike_out, 4'b0001);
    tick("leak_idle");

    // Refractory 3 on channel 1: fires at steps 1, 5, 9.
    do_reset();
    cfg(2'd3, 8'd3);
    cfg(2'd1, 8'd100);
    v_sel = 2'd1;
    stp("refrac", 4'b0010, 10);
    tick("refrac_idle");
    chk("refrac_count", spike_count, 3);

    // Saturation: 200 + 200 clamps to 255 and fires at thr 255.
    do_reset();
    v_sel = 2'd0;
    cfg(2'd0, 8'd255);
    cfg(2'd1, 8'd200);
    stp("sat", 4'b0001, 2);
    chk("sat_fire", spike_out, 4'b0001);
    tick("sat_idle");
    chk("sat_count", spike_count, 1);

    // All channels fire together, then a config write coincident with a step.
    do_reset();
    stp("all4", 4'b1111, 4);
    chk("all4_count", spike_count, 4);
    step = 1'b1; spike_in = 4'b0001;
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd10;
    tick("cfgstep");
    chk("cfgstep_old_thr", spike_out, 4'b0000);
    cfg_we = 1'b0;
    tick("cfgstep_new_thr");
    chk("cfgstep_new_fire", spike_out, 4'b0001);
    step = 1'b0; spike_in = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      v_sel = 2'(i);
      tick("hold");
    end

    // Reset mid-operation with V0=90 and R2=2.
    do_reset();
    cfg(2'd3, 8'd2);
    stp("mid_a", 4'b0101, 3);
    stp("mid_b", 4'b0100, 1);
    v_sel = 2'd0;
    tick("mid_v0");
    chk("mid_v0_90", v_mon, 90);
    rst = 1'b1; step = 1'b1; spike_in = 4'b1111;
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd5;
    tick("mid_rst");
    rst = 1'b0; cfg_we = 1'b0;
    chk("mid_rst_spike", spike_out, 0);
    chk("mid_rst_count", spike_count, 0);
    stp("post_rst", 4'b0101, 1);
    tick("post_rst_mon");
    chk("post_rst_v0", v_mon, 30);
    v_sel = 2'd2;
    tick("post_rst_mon2");
    chk("post_rst_v2", v_mon, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised multi-channel leaky integrate-and-fire (LIF) neuron core, the next-generation replacement for the single-channel LIF core behind the Tiny Tapeout top-level wrapper. It integrates N_CH independent neurons in parallel. It adds features the single neuron lacks:
- configurable width, threshold, synaptic weight, leak and refractory period;
- a global step enable;
- a membrane-potential monitor port;
- a saturating spike counter.

The wrapper instantiates it, maps `ui_in` bits to `spike_in`, drives `uo_out` from `spike_out`, and uses `uio` for configuration.

## Interface
- `N_CH`, 4: number of neuron channels (1–8).
- `W`, 8: membrane potential, threshold and weight width in bits (4–16).
- `THRESH_INIT`, 100: threshold after reset.
- `WEIGHT_INIT`, 30: synaptic weight after reset.
- `LEAK_INIT`, 0: leak shift after reset (0 = no leak).
- `REFRAC_INIT`, 0: refractory steps after reset.
- `clk`, in, 1: the only clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `step`, in, 1: advance all neurons by one time step in this cycle.
- `spike_in`, in, N_CH: per-channel input spike, sampled only when `step`=1.
- `cfg_we`, in, 1: configuration write strobe.
- `cfg_sel`, in, 2: configuration register select. 0 = threshold, 1 = weight, 2 = leak shift (low 4 bits used), 3 = refractory steps (low 8 bits used).
- `cfg_data`, in, W: configuration write data.
- `v_sel`, in, clog2(N_CH) (min 1): channel shown on `v_mon`.
- `spike_out`, out, N_CH: registered one-cycle spike pulse per channel.
- `v_mon`, out, W: registered membrane potential of channel `v_sel`.
- `spike_count`, out, 16: saturating count of all output spikes since reset.

## Operation
- **Per-channel state:** potential `V` (W bits) and refractory counter `R` (8 bits).
- **Shared configuration registers:** `thr`, `wgt`, `lk`, `rf`, applied to all channels.
- **Idle:** when `step`=0, `V`, `R` and `spike_count` hold. `spike_out` is 0.
- **Refractory step** (`step`=1, `R`≠0): decrement `R`, hold `V` at 0, ignore `spike_in`, no spike.
- **Integrate step** (`step`=1, `R`=0):
  - leak term `L` = (`lk`=0) ? 0 : `V` >> `lk`;
  - `S` = `V` − `L` + (`spike_in`[i] ? `wgt` : 0), computed in W+1 bits;
  - if `S` > 2^W−1, `S` saturates to 2^W−1 and never wraps.
- **Fire:** if `S` ≥ `thr`, then `spike_out`[i]=1 for the next cycle, `V`←0 and `R`←`rf`. Otherwise `V`←`S`.
  - `thr`=0 makes the channel fire on every integrate step.
- **Spike counter:** `spike_count` increments by the popcount of the spikes fired this step and saturates at 65535.
- **Configuration writes:** when `cfg_we`=1, the selected register loads `cfg_data` (truncated per field).
  - A write in the same cycle as `step` does not affect that step; the step uses the old value and the new value applies from the next cycle.
  - Lowering `rf` does not alter running `R` counters.
- **Monitor:** `v_mon` ← `V`[`v_sel`] every cycle, showing the post-update value one cycle after the update.
  - An out-of-range `v_sel` returns 0.

## Timing
- **Reset:** on `rst`=1 at a clock edge:
  - all `V`=0, `R`=0;
  - `spike_out`=0, `v_mon`=0, `spike_count`=0;
  - `thr`/`wgt`/`lk`/`rf` ← `*_INIT`.
- `rst` takes priority over `step` and `cfg_we` in the same cycle. Reset mid-operation discards all potentials and refractory state immediately.
- **Latency:** `spike_in` sampled at edge k (with `step`) gives `spike_out` high during cycle k+1. The pulse lasts exactly 1 cycle even if `step` stays high.
- **`v_mon` latency:** reflects `V` one cycle after the edge that updated it.
- **Refractory period:** a channel that fires at step n ignores steps n+1 … n+`rf` and integrates again at step n+`rf`+1.
- **Back-to-back steps:** `step` may be high every cycle; there are no bubbles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Linear integration:** reset; `thr`=100, `wgt`=30, `lk`=0; `spike_in`[0]=1 with `step` for 4 cycles.
  - `v_mon` reads 30, 60, 90.
  - `spike_out`[0] pulses once in the cycle after the 4th step; `V`[0]=0; `spike_count`=1.
- **Leak:** `lk`=2, same stimulus.
  - `V` = 30, 53, 70, 83, 93, then fire on the 6th step.
  - No spike before the 6th step.
- **Refractory:** `rf`=3, `wgt`=100, `thr`=100; `spike_in`[1]=1 every step.
  - `spike_out`[1] fires at steps 1, 5, 9.
  - `V`[1] stays 0 during steps 2–4.
- **Saturation:** `thr`=255, `wgt`=200, `lk`=0; 2 input steps.
  - Step 2 saturates to 255 and fires; it must not wrap to 144.
  - `spike_count`=1.
- **Simultaneous events:**
  - All 4 channels fire in one step → `spike_count` +4.
  - `cfg_we` (`thr`=10) in the same cycle as a step → that step uses the old `thr`.
  - `step`=0 → all state holds.
- **Reset mid-operation:** assert `rst` with `V`[0]=90 and `R`[2]=2.
  - Next cycle all outputs are 0 and config returns to `*_INIT`.
  - The following input step gives `V`[0]=30.
